// File: rtl/prime_range_scanner.sv
// prime_range_scanner: walks every integer in [num_min, num_max] and classifies
// each one as prime or composite by iterative trial division, one divisor per
// clock. One valid strobe per candidate, a saturating running prime count, and
// a start/busy/done handshake so scans can be relaunched without a reset.
module prime_range_scanner #(
    parameter int WIDTH     = 11,
    parameter int CNT_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     num_min,
    input  logic [WIDTH-1:0]     num_max,
    output logic                 busy,
    output logic                 valid,
    output logic                 prime,
    output logic [WIDTH-1:0]     number_checked,
    output logic [CNT_WIDTH-1:0] number_of_primes,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TEST,
        S_EMIT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_max;
    logic [WIDTH-1:0]    r_n;
    logic [WIDTH-1:0]    r_d;

    logic [2*WIDTH-1:0]  w_square;
    logic [2*WIDTH-1:0]  w_nWide;
    logic [WIDTH-1:0]    w_rem;
    logic                w_squareAbove;
    logic                w_divides;
    logic                w_countFull;

    // The divisor square is formed at double width so that a large divisor can
    // never wrap around and falsely declare a composite number prime.
    assign w_square      = {{WIDTH{1'b0}}, r_d} * {{WIDTH{1'b0}}, r_d};
    assign w_nWide       = {{WIDTH{1'b0}}, r_n};
    assign w_squareAbove = (w_square > w_nWide);
    assign w_rem         = r_n % r_d;
    assign w_divides     = (w_rem == '0);
    assign w_countFull   = &number_of_primes;

    // Scan sequencer: all outputs are registered and updated on the transition
    // into the state where they must be visible (valid in EMIT, done in DONE).
    // End of scan is detected by comparing n with max before incrementing, so
    // a window ending at the all-ones value terminates without wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_max            <= '0;
            r_n              <= '0;
            r_d              <= '0;
            busy             <= 1'b0;
            valid            <= 1'b0;
            prime            <= 1'b0;
            number_checked   <= '0;
            number_of_primes <= '0;
            done             <= 1'b0;
        end else begin
            valid <= 1'b0;
            done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        r_max            <= num_max;
                        number_of_primes <= '0;
                        if (num_min > num_max) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_n     <= num_min;
                            r_state <= S_LOAD;
                            busy    <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    r_d <= WIDTH'(2);
                    if (r_n < WIDTH'(2)) begin
                        valid          <= 1'b1;
                        prime          <= 1'b0;
                        number_checked <= r_n;
                        r_state        <= S_EMIT;
                    end else begin
                        r_state <= S_TEST;
                    end
                end

                S_TEST: begin
                    if (w_squareAbove) begin
                        valid          <= 1'b1;
                        prime          <= 1'b1;
                        number_checked <= r_n;
                        if (!w_countFull) begin
                            number_of_primes <= number_of_primes + CNT_WIDTH'(1);
                        end
                        r_state <= S_EMIT;
                    end else if (w_divides) begin
                        valid          <= 1'b1;
                        prime          <= 1'b0;
                        number_checked <= r_n;
                        r_state        <= S_EMIT;
                    end else begin
                        r_d <= r_d + WIDTH'(1);
                    end
                end

                S_EMIT: begin
                    if (r_n == r_max) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        r_n     <= r_n + WIDTH'(1);
                        r_state <= S_LOAD;
                    end
                end

                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prime_range_scanner.sv
// tb_prime_range_scanner: directed scans of the prime range scanner with a
// scoreboard queue of expected strobes, cycle-exact timing checks, a narrow
// WIDTH=4 instance for the top-of-range case, and a mid-scan reset.
module tb_prime_range_scanner;

    typedef struct {
        logic [10:0] n;
        logic        p;
        logic [10:0] cnt;
    } expect_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] num_min;
    logic [10:0] num_max;
    logic        busy;
    logic        valid;
    logic        prime;
    logic [10:0] number_checked;
    logic [10:0] number_of_primes;
    logic        done;

    logic        start4;
    logic [3:0]  num_min4;
    logic [3:0]  num_max4;
    logic        busy4;
    logic        valid4;
    logic        prime4;
    logic [3:0]  number_checked4;
    logic [10:0] number_of_primes4;
    logic        done4;

    int          checks;
    int          errors;
    int          strobeCount;
    int          doneCount;
    expect_t     sbQueue[$];

    prime_range_scanner #(.WIDTH(11), .CNT_WIDTH(11)) dut (
        .clk(clk), .rst(rst), .start(start), .num_min(num_min), .num_max(num_max),
        .busy(busy), .valid(valid), .prime(prime), .number_checked(number_checked),
        .number_of_primes(number_of_primes), .done(done)
    );

    prime_range_scanner #(.WIDTH(4), .CNT_WIDTH(11)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .num_min(num_min4), .num_max(num_max4),
        .busy(busy4), .valid(valid4), .prime(prime4), .number_checked(number_checked4),
        .number_of_primes(number_of_primes4), .done(done4)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something never finishes
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic isPrimeRef(int n);
        if (n < 2) return 1'b0;
        for (int k = 2; k * k <= n; k++) begin
            if (n % k == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives a one-cycle start pulse; returns #1 after the accepting edge.
    // With pushModel set, the expected strobes of the window are queued.
    task automatic applyStimulus(input int lo, input int hi, input bit pushModel);
        int      runCount;
        expect_t e;
        runCount = 0;
        if (pushModel) begin
            for (int v = lo; v <= hi; v++) begin
                e.n = 11'(v);
                e.p = isPrimeRef(v);
                if (e.p) runCount++;
                e.cnt = 11'(runCount);
                sbQueue.push_back(e);
            end
        end
        num_min = 11'(lo);
        num_max = 11'(hi);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (done) break;
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_doneSeen"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "_sbDrained"}, sbQueue.size(), 32'd0);
    endtask

    task automatic pushExpected(input int n, input logic p, input int cnt);
        expect_t e;
        e.n   = 11'(n);
        e.p   = p;
        e.cnt = 11'(cnt);
        sbQueue.push_back(e);
    endtask

    // Scoreboard consumer: compares each strobe against the queue head
    always @(negedge clk) begin
        if (valid) begin
            strobeCount++;
            checkOutput("strobeExpected", {31'd0, sbQueue.size() != 0}, 32'd1);
            if (sbQueue.size() != 0) begin
                expect_t e;
                e = sbQueue.pop_front();
                checkOutput("numberChecked", {21'd0, number_checked}, {21'd0, e.n});
                checkOutput("primeFlag", {31'd0, prime}, {31'd0, e.p});
                checkOutput("primeCount", {21'd0, number_of_primes}, {21'd0, e.cnt});
            end
        end
        if (done) doneCount++;
        if (valid || done) checkOutput("validDoneOverlap", {31'd0, valid && done}, 32'd0);
    end

    initial begin
        int          doneBefore;
        int          strobesBefore;
        int          localStrobes;
        int          idx4;
        bit          doneSeen4;
        logic [3:0]  expN4 [3];
        logic        expP4 [3];

        checks      = 0;
        errors      = 0;
        strobeCount = 0;
        doneCount   = 0;
        rst         = 1'b0;
        start       = 1'b0;
        num_min     = '0;
        num_max     = '0;
        start4      = 1'b0;
        num_min4    = '0;
        num_max4    = '0;

        // Reset held for two edges; every output must be zero
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_valid", {31'd0, valid}, 32'd0);
        checkOutput("rst_prime", {31'd0, prime}, 32'd0);
        checkOutput("rst_number", {21'd0, number_checked}, 32'd0);
        checkOutput("rst_count", {21'd0, number_of_primes}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_done4", {31'd0, done4}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] scan 0..100");
        doneBefore    = doneCount;
        strobesBefore = strobeCount;
        applyStimulus(0, 100, 1'b1);
        waitDone("scan100", 3000);
        checkOutput("scan100_count", {21'd0, number_of_primes}, 32'd25);
        @(posedge clk);
        #1;
        checkOutput("scan100_strobes", strobeCount - strobesBefore, 32'd101);
        checkOutput("scan100_donePulses", doneCount - doneBefore, 32'd1);
        checkOutput("scan100_busyAfter", {31'd0, busy}, 32'd0);
        checkOutput("scan100_countHeld", {21'd0, number_of_primes}, 32'd25);

        $display("[TB] scan 2..10");
        pushExpected(2, 1'b1, 1);
        pushExpected(3, 1'b1, 2);
        pushExpected(4, 1'b0, 2);
        pushExpected(5, 1'b1, 3);
        pushExpected(6, 1'b0, 3);
        pushExpected(7, 1'b1, 4);
        pushExpected(8, 1'b0, 4);
        pushExpected(9, 1'b0, 4);
        pushExpected(10, 1'b0, 4);
        applyStimulus(2, 10, 1'b0);
        waitDone("scan2to10", 500);
        checkOutput("scan2to10_count", {21'd0, number_of_primes}, 32'd4);
        @(posedge clk);
        #1;

        $display("[TB] timing for 97 and 91");
        applyStimulus(97, 97, 1'b1);
        for (int k = 1; k <= 13; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            checkOutput("t97_valid", {31'd0, valid}, {31'd0, k == 11});
            checkOutput("t97_done", {31'd0, done}, {31'd0, k == 12});
            checkOutput("t97_busy", {31'd0, busy}, {31'd0, k < 12});
        end
        applyStimulus(91, 91, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            checkOutput("t91_valid", {31'd0, valid}, {31'd0, k == 8});
            checkOutput("t91_done", {31'd0, done}, {31'd0, k == 9});
        end
        checkOutput("t91_count", {21'd0, number_of_primes}, 32'd0);
        checkOutput("t91_primeHeld", {31'd0, prime}, 32'd0);

        $display("[TB] empty window 20..10");
        applyStimulus(97, 97, 1'b1);
        waitDone("refill97", 100);
        @(posedge clk);
        #1;
        strobesBefore = strobeCount;
        applyStimulus(20, 10, 1'b1);
        checkOutput("empty_doneNextCycle", {31'd0, done}, 32'd1);
        checkOutput("empty_busy", {31'd0, busy}, 32'd0);
        checkOutput("empty_count", {21'd0, number_of_primes}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("empty_noStrobes", strobeCount - strobesBefore, 32'd0);

        $display("[TB] WIDTH=4 scan 13..15");
        expN4[0] = 4'd13; expN4[1] = 4'd14; expN4[2] = 4'd15;
        expP4[0] = 1'b1;  expP4[1] = 1'b0;  expP4[2] = 1'b0;
        idx4      = 0;
        doneSeen4 = 1'b0;
        num_min4  = 4'd13;
        num_max4  = 4'd15;
        start4    = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        for (int c = 0; c < 120; c++) begin
            if (valid4) begin
                if (idx4 < 3) begin
                    checkOutput("w4_number", {28'd0, number_checked4}, {28'd0, expN4[idx4]});
                    checkOutput("w4_prime", {31'd0, prime4}, {31'd0, expP4[idx4]});
                    checkOutput("w4_count", {21'd0, number_of_primes4}, 32'd1);
                end
                idx4++;
            end
            if (done4) begin
                doneSeen4 = 1'b1;
                checkOutput("w4_doneAfterLast", idx4, 32'd3);
            end
            @(posedge clk);
            #1;
        end
        checkOutput("w4_strobeTotal", idx4, 32'd3);
        checkOutput("w4_doneSeen", {31'd0, doneSeen4}, 32'd1);
        checkOutput("w4_busyAfter", {31'd0, busy4}, 32'd0);

        $display("[TB] reset mid-scan, then 0..10 with ignored starts");
        applyStimulus(0, 100, 1'b1);
        localStrobes = 0;
        for (int c = 0; c < 3000; c++) begin
            if (valid) localStrobes++;
            if (localStrobes == 40) break;
            @(posedge clk);
            #1;
        end
        checkOutput("abort_reached40", localStrobes, 32'd40);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_valid", {31'd0, valid}, 32'd0);
        checkOutput("abort_prime", {31'd0, prime}, 32'd0);
        checkOutput("abort_number", {21'd0, number_checked}, 32'd0);
        checkOutput("abort_count", {21'd0, number_of_primes}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        sbQueue.delete();
        @(posedge clk);
        #1;

        applyStimulus(0, 10, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        num_min = 11'd50;
        num_max = 11'd60;
        start   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busyStart_stillBusy", {31'd0, busy}, 32'd1);
        waitDone("scan0to10", 500);
        checkOutput("scan0to10_count", {21'd0, number_of_primes}, 32'd4);

        strobesBefore = strobeCount;
        num_min = 11'd5;
        num_max = 11'd5;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("doneStart_noStrobes", strobeCount - strobesBefore, 32'd0);
        checkOutput("doneStart_busy", {31'd0, busy}, 32'd0);
        checkOutput("doneStart_countHeld", {21'd0, number_of_primes}, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prime_range_scanner.md
Name: prime_range_scanner

Overview:
Parametrised successor to the single-range prime checker. It scans every integer in a programmable window [num_min, num_max] and classifies each one as prime or composite using an iterative trial-division FSM. It emits one result strobe per candidate and keeps a running prime count. A start/busy/done handshake lets a controller or bench launch repeated scans without resetting.

Parameters:
WIDTH, 11, bit width of candidate numbers and range bounds
CNT_WIDTH, 11, bit width of prime counter; saturates at all-ones

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, synchronous, active-low
start  input  1  launch request; sampled only in IDLE
num_min  input  WIDTH  first candidate; latched when start is accepted
num_max  input  WIDTH  last candidate; latched when start is accepted
busy  output  1  high from the cycle after start is accepted until DONE
valid  output  1  one-cycle strobe per classified candidate
prime  output  1  classification of number_checked; qualified by valid
number_checked  output  WIDTH  candidate just classified
number_of_primes  output  CNT_WIDTH  primes found so far in the current scan
done  output  1  one-cycle pulse at end of scan

Behaviour:
- Reset: one clock; reset is synchronous and active-low (rst low at a rising clk edge).
  - All outputs go to 0 and the FSM goes to IDLE.
  - Reset overrides every other input, including mid-scan.
- FSM states and transitions:
  - IDLE: busy=0. When start=1, latch min/max and clear number_of_primes.
    - If min>max, go to DONE.
    - Otherwise set n=min and go to LOAD.
  - LOAD: set d=2.
    - If n<2, mark composite and go to EMIT.
    - Otherwise go to TEST.
  - TEST: one divisor per cycle.
    - If d*d > n, mark prime and go to EMIT.
    - Else if n mod d == 0, mark composite and go to EMIT.
    - Else d = d+1 and stay in TEST.
  - EMIT: valid=1 for this cycle only.
    - In this cycle, number_checked=n and prime=the classification.
    - number_of_primes already includes this candidate (incremented if prime, saturating at 2^CNT_WIDTH-1).
    - If n==max, go to DONE; else n=n+1 and go to LOAD.
  - DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Arithmetic and widths:
  - d is WIDTH bits.
  - d*d is computed at 2*WIDTH bits, so there is no overflow false-prime.
  - End-of-scan is detected by n==max before incrementing, so num_max=2^WIDTH-1 never wraps to 0.
- Latency per candidate = 1 (LOAD) + T (TEST cycles) + 1 (EMIT).
  - T=0 for n<2.
  - Composite: T = (smallest divisor) - 1.
  - Prime: T = floor(sqrt(n)).
- Hold and start rules:
  - prime, number_checked and number_of_primes hold their last values between strobes and after done, until the next accepted start.
  - start asserted in any state other than IDLE (including the DONE cycle) is ignored.
  - Changes on num_min/num_max after acceptance have no effect.
- valid and done are never high in the same cycle.

Test Plan:
1. rst low 2 cycles, then num_min=0, num_max=100, start pulse -> 101 valid strobes with number_checked 0..100 in order; prime high exactly for the 25 primes 2..97; final number_of_primes=25; single done pulse; busy low afterwards.
2. num_min=2, num_max=10 -> prime flags per strobe 1,1,0,1,0,1,0,0,0 (n=2..10); number_of_primes steps 1,2,2,3,3,4,4,4,4; done after the n=10 strobe.
3. num_min=num_max=97, start sampled at edge 0 -> LOAD at cycle 1, TEST d=2..10 at cycles 2–10, valid=1 with prime=1 and count=1 at cycle 11, done at cycle 12. Repeat with 91 -> composite found at d=7, valid at cycle 8, prime=0.
4. num_min=20, num_max=10 -> no valid strobes; done pulses the cycle after start is accepted; number_of_primes=0.
5. WIDTH=4 instance, num_min=13, num_max=15 -> flags 1,0,0; count 1; done after n=15; no strobe for n=0 (no wrap).
6. Mid-scan of 0..100: drive rst low at the 40th strobe -> next edge all outputs 0, busy 0. Then start 0..10 -> count ends at 4, unaffected by the aborted scan. Also assert start while busy -> no effect on the scan.
